// File: rtl/debounce_pkg.sv
// Shared types and constants for the button debouncer.
// Debounce counter width, default qualification time and FSM states.
package debounce_pkg;

  localparam int DEBOUNCE_CNT_W      = 24;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

  typedef logic [DEBOUNCE_CNT_W-1:0] db_cnt_t;

  typedef enum logic [1:0] {
    IDLE_LOW    = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Reusable for any slow asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button into a level plus press/release strobes.
// A level change is accepted after DEBOUNCE_CYCLES stable samples.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      button_in,
  output logic                      ButtonHold,
  output logic                      press_pulse,
  output logic                      release_pulse,
  output logic [DEBOUNCE_CNT_W-1:0] stable_count
);

  localparam db_cnt_t LAST = db_cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam db_cnt_t ONE  = db_cnt_t'(1);

  logic      s;
  db_state_t state, state_n;
  db_cnt_t   cnt, cnt_n;
  logic      hold_n, press_n, rel_n;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (button_in),
    .q     (s)
  );

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    unique case (state)
      IDLE_LOW: begin
        if (s) begin
          state_n = WAIT_HIGH;
          cnt_n   = ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_n = IDLE_LOW;
        end else if (cnt == LAST) begin
          state_n = STABLE_HIGH;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_n = WAIT_LOW;
          cnt_n   = ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_n = STABLE_HIGH;
        end else if (cnt == LAST) begin
          state_n = IDLE_LOW;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = IDLE_LOW;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land with it.
  always_comb begin
    hold_n  = (state_n == STABLE_HIGH) || (state_n == WAIT_LOW);
    press_n = (state == WAIT_HIGH) && (state_n == STABLE_HIGH);
    rel_n   = (state == WAIT_LOW) && (state_n == IDLE_LOW);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE_LOW;
      cnt           <= '0;
      ButtonHold    <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      ButtonHold    <= hold_n;
      press_pulse   <= press_n;
      release_pulse <= rel_n;
    end
  end

  assign stable_count = cnt;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with DEBOUNCE_CYCLES=4.
// A run-length reference model feeds a per-cycle scoreboard.
module tb_button_debouncer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        button_in;
  logic        ButtonHold;
  logic        press_pulse;
  logic        release_pulse;
  logic [23:0] stable_count;

  always #5 clk = ~clk;

  button_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .button_in     (button_in),
    .ButtonHold    (ButtonHold),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .stable_count  (stable_count)
  );

  typedef struct packed {
    logic        hold;
    logic        press;
    logic        rel;
    logic [23:0] cnt;
  } obs_t;

  obs_t exp_q[$];

  int checks = 0;
  int errors = 0;

  bit m_s1, m_s2, m_hold;
  int m_run;

  int edge_idx, rise_edge, press_edge, rel_edge;
  int n_press, n_rel, hold_cyc, max_cnt;
  int glob_max = 0;
  int overlap  = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    m_hold = 1'b0;
    m_run  = 0;
  endtask

  task automatic clr_stats();
    edge_idx   = 0;
    rise_edge  = -1;
    press_edge = -1;
    rel_edge   = -1;
    n_press    = 0;
    n_rel      = 0;
    hold_cyc   = 0;
    max_cnt    = 0;
  endtask

  // One clock: drive input, predict, then compare after the edge.
  task automatic step(bit b);
    obs_t e;
    obs_t o;
    bit   sv;
    @(negedge clk);
    button_in = b;
    e = '0;
    if (!reset) begin
      model_reset();
    end else begin
      sv   = m_s2;
      m_s2 = m_s1;
      m_s1 = b;
      if (sv != m_hold) begin
        m_run++;
        if (m_run == N) begin
          m_hold  = sv;
          e.press = sv;
          e.rel   = !sv;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      e.hold = m_hold;
      e.cnt  = 24'(m_run);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = {ButtonHold, press_pulse, release_pulse, stable_count};
    e = exp_q.pop_front();
    check("cycle", 32'(o), 32'(e));
    edge_idx++;
    if (press_pulse) begin
      n_press++;
      press_edge = edge_idx;
    end
    if (release_pulse) begin
      n_rel++;
      rel_edge = edge_idx;
    end
    if (ButtonHold) hold_cyc++;
    if (ButtonHold && rise_edge < 0) rise_edge = edge_idx;
    if (int'(stable_count) > max_cnt) max_cnt = int'(stable_count);
    if (int'(stable_count) > glob_max) glob_max = int'(stable_count);
    if (press_pulse && release_pulse) overlap++;
  endtask

  initial begin
    reset     = 1'b0;
    button_in = 1'b1;
    model_reset();
    clr_stats();
    #1;
    check("rst_out", 32'({ButtonHold, press_pulse, release_pulse,
                          stable_count}), 32'd0);
    repeat (2) step(1'b1);

    // Release reset with the button already held.
    clr_stats();
    reset = 1'b1;
    repeat (10) step(1'b1);
    check("rst_rise_edge", rise_edge, N + 2);
    check("rst_press_edge", press_edge, N + 2);
    check("rst_press_cnt", n_press, 1);
    repeat (12) step(1'b0);

    // Short blip is rejected.
    clr_stats();
    repeat (3) step(1'b1);
    repeat (8) step(1'b0);
    check("blip_peak", max_cnt, 3);
    check("blip_hold", hold_cyc, 0);
    check("blip_press", n_press, 0);
    check("blip_rel", n_rel, 0);

    // Clean 10-cycle press.
    clr_stats();
    repeat (10) step(1'b1);
    repeat (14) step(1'b0);
    check("press_hold_len", hold_cyc, 10);
    check("press_cnt", n_press, 1);
    check("press_rel_cnt", n_rel, 1);
    check("press_gap", rel_edge - press_edge, 10);

    // Low glitch while held.
    clr_stats();
    repeat (10) step(1'b1);
    repeat (2) step(1'b0);
    repeat (10) step(1'b1);
    check("glitch_rel", n_rel, 0);
    check("glitch_hold", ButtonHold, 1);
    check("glitch_cnt", stable_count, 0);

    // Reset in the middle of a release qualification.
    clr_stats();
    repeat (4) step(1'b0);
    check("wl_cnt", stable_count, 2);
    check("wl_hold", ButtonHold, 1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst", 32'({ButtonHold, press_pulse, release_pulse,
                            stable_count}), 32'd0);
    repeat (2) step(1'b0);
    reset = 1'b1;
    repeat (12) step(1'b0);
    check("rst_no_rel", n_rel, 0);

    // Long steady hold does not re-trigger.
    clr_stats();
    repeat (30) step(1'b1);
    check("long_press", n_press, 1);
    check("long_hold", hold_cyc, 25);
    check("long_cnt", max_cnt, N - 1);
    repeat (12) step(1'b0);

    // Random bounce runs checked against the model.
    clr_stats();
    for (int i = 0; i < 40; i++) begin
      int len;
      len = int'($urandom_range(1, 7));
      repeat (len) step(1'(i % 2 == 0));
    end
    repeat (12) step(1'b0);

    check("max_cnt", glob_max, N - 1);
    check("overlap", overlap, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
